sram_pixel_writer: RTL
======================

// Module: sram_pixel_writer
// PURPOSE
//  Write side of the SRAM framebuffer: accepts pixel writes (x, y, RGB565) on a valid/ready
//  port, buffers them in a FIFO, and issues asynchronous-SRAM write cycles only while the
//  display scan-out does not own the bus (bus_grant=1). Addressing (y*640+x) and the RGB565
//  packing {R[15:11],G[10:5],B[4:0]} match what scan-out reads; tri-states the bus when not granted.
// PARAMETERS
//  H_RES        640   pixels per line; address = y*H_RES + x
//  V_RES        480   lines per frame; y >= V_RES is out of range
//  FIFO_DEPTH   16    pixel FIFO entries (power of 2)
// PORTS
//  clk          in   1   50 MHz clock
//  rst          in   1   asynchronous reset, active high
//  pix_valid    in   1   pixel write request
//  pix_ready    out  1   FIFO can accept (= !full)
//  pix_x        in   10  pixel x
//  pix_y        in   9   pixel y
//  pix_rgb      in   16  RGB565 colour
//  bus_grant    in   1   1 = writer may drive SRAM (display blanking/idle)
//  busy         out  1   FIFO non-empty or write/clear in progress
//  err_oob      out  1   one-cycle pulse: popped pixel was out of range, discarded
//  SRAM_ADDR    out  20  word address; Z when not granted
//  SRAM_DQ      inout 16 write data; Z except SETUP/STROBE/HOLD
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out 1 each; Z when not granted
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, pix_ready=1, busy=0, err_oob=0, all SRAM outputs Z.
//  Reset is asynchronous, active high; clock clk. Reset mid-cycle aborts immediately, bus Z next.
//  Handshake: push when pix_valid&pix_ready (same-cycle push+pop allowed when full: pop frees slot next cycle only).
//  Granted, non-write: CE_N=0, OE_N=1, WE_N=1, UB_N=LB_N=0, DQ=Z.
//  FSM (advances only while bus_grant=1):
//   IDLE   -> if FIFO non-empty: out-of-range head (x>=H_RES | y>=V_RES): pop, pulse err_oob, stay IDLE;
//             else -> SETUP
//   SETUP  ADDR=y*H_RES+x (20-bit, zero-extended), DQ=rgb, WE_N=1 -> STROBE
//   STROBE WE_N=0, ADDR/DQ held -> HOLD
//   HOLD   WE_N=1, ADDR/DQ held; pop head -> IDLE
//  Write = 3 cycles; sustained 1 pixel / 3 cycles under continuous grant.
//  Grant drop in SETUP/STROBE/HOLD: bus Z same cycle (combinational on bus_grant), FSM -> IDLE,
//   head NOT popped; pixel rewritten in full when grant returns (idempotent retry).
//  Full FIFO: pix_ready=0, inputs ignored. Empty FIFO: FSM stays IDLE, busy=0.
//  Pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer MSB.
// CONFIGURATION
//  FB_CLEAR_EN defined: extra ports clear_req(in,1), clear_rgb(in,16). clear_req in IDLE with FIFO
//   empty starts fill of addresses 0..H_RES*V_RES-1 with clear_rgb (captured at start), same
//   SETUP/STROBE/HOLD cycle per word; pix_ready=0 during fill; grant drop resumes at same address;
//   busy=1 until last word. clear_req while FIFO non-empty waits for drain.
//  FB_CLEAR_EN undefined: no clear ports/logic; behaviour as above only.
// TESTING
//  1 Reset: rst=1 -> SRAM pins Z, pix_ready=1, busy=0; hold bus_grant=1 after release -> CE_N=0, WE_N=1.
//  2 Single write: (x=5,y=2,rgb=16'hF800), grant=1 -> ADDR=20'd1285, DQ=F800, one WE_N low cycle, busy 0 after HOLD.
//  3 Backpressure: grant=0, push 17 pixels -> 16 accepted, pix_ready=0; grant=1 -> 16 writes in order, 48 cycles.
//  4 Grant drop in STROBE for pixel (639,479,16'h07E0) -> bus Z same cycle; on regrant ADDR=20'd307199 rewritten, FIFO count unchanged until HOLD.
//  5 Out of range: push (x=640,y=0) then (0,0) -> err_oob one pulse, no WE_N low for first, write to ADDR 0 follows.
//  6 FB_CLEAR_EN: clear_req, clear_rgb=16'h001F, grant=1 -> 307200 writes ADDR 0..307199, busy falls after 921600 cycles.

Source files
------------

// File: rtl/sram_pixel_writer_if.sv
// Pixel write port of the SRAM framebuffer writer.
//   pix_valid  producer has a pixel to write
//   pix_ready  writer can accept it this cycle
//   pix_x      pixel column (10 bits)
//   pix_y      pixel row (9 bits)
//   pix_rgb    RGB565 colour {R[15:11], G[10:5], B[4:0]}
// master: the pixel producer; slave: the writer.
interface sram_pixel_writer_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_rgb;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_rgb,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_rgb,
        output pix_ready
    );
endinterface

// File: rtl/sram_pixel_writer.sv
// Write side of the SRAM framebuffer. Pixels arrive on a valid/ready port, wait in a FIFO and
// are written to asynchronous SRAM with a SETUP/STROBE/HOLD cycle while the display scan-out
// has released the bus (bus_grant=1). Word address is y*H_RES+x. All SRAM pins float whenever
// the bus is not granted or reset is asserted.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pix             pixel write port (sram_pixel_writer_if.slave)
//   clear_req       start a full-frame fill (FB_CLEAR_EN builds only)
//   clear_rgb       fill colour, captured when the fill starts (FB_CLEAR_EN builds only)
//   bus_grant       1 = this block may drive the SRAM
//   busy            FIFO non-empty, write in progress or fill in progress
//   err_oob         one-cycle pulse after an out-of-range pixel was discarded
//   SRAM_*          asynchronous SRAM pins, Z when not granted
//
// Build option: define FB_CLEAR_EN to add the frame-clear engine and its ports.
module sram_pixel_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    sram_pixel_writer_if.slave        pix,
`ifdef FB_CLEAR_EN
    input  logic                      clear_req,
    input  logic [15:0]               clear_rgb,
`endif
    input  logic                      bus_grant,
    output logic                      busy,
    output logic                      err_oob,
    output wire  [19:0]               SRAM_ADDR,
    inout  wire  [15:0]               SRAM_DQ,
    output wire                       SRAM_CE_N,
    output wire                       SRAM_OE_N,
    output wire                       SRAM_WE_N,
    output wire                       SRAM_UB_N,
    output wire                       SRAM_LB_N
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [15:0] rgb;
    } pix_entry_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_e      state_q, state_d;

    pix_entry_t  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, rd_ptr_p1;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    pix_entry_t  head, peek;
    logic        peek_valid;

    logic [19:0] addr_q;
    logic [15:0] data_q;
    logic        load_en;
    logic [19:0] load_addr;
    logic [15:0] load_data;

    logic        oob_pop;
    logic        err_oob_q;

    logic        clr_active;
    logic        clr_start;
    logic        clr_last;
    logic [19:0] clr_addr_cur;
    logic [19:0] clr_addr_next;
    logic [15:0] clr_rgb_cur;
    logic [15:0] clr_rgb_start;

    logic        drive_en;
    logic        dq_en;

    function automatic logic [19:0] entry_addr(pix_entry_t e);
        return 20'(e.y) * 20'(H_RES) + 20'(e.x);
    endfunction

    function automatic logic entry_oob(pix_entry_t e);
        return (32'(e.x) >= H_RES) || (32'(e.y) >= V_RES);
    endfunction

    // ------------------------------------------------------------------
    // Pixel FIFO: extra pointer MSB distinguishes full from empty
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_ptr_p1  = rd_ptr_q + 1'b1;

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    // Entry behind the head, so HOLD can chain straight into the next SETUP.
    assign peek       = mem_q[rd_ptr_p1[AW-1:0]];
    assign peek_valid = (wr_ptr_q != rd_ptr_p1);

    assign pix.pix_ready = !fifo_full && !clr_active;
    assign push          = pix.pix_valid && pix.pix_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{x: pix.pix_x, y: pix.pix_y, rgb: pix.pix_rgb};
        end
    end

    // ------------------------------------------------------------------
    // Frame-clear engine
    // ------------------------------------------------------------------
`ifdef FB_CLEAR_EN
    localparam logic [19:0] ClrLast = 20'(H_RES * V_RES - 1);

    logic        clr_active_q;
    logic [19:0] clr_addr_q;
    logic [15:0] clr_rgb_q;
    logic        clr_step;

    assign clr_active    = clr_active_q;
    // Waits for the FIFO to drain before starting.
    assign clr_start     = clear_req && !clr_active_q && (state_q == StIdle) && fifo_empty;
    // A word is complete only when HOLD finishes under grant; a drop retries the same address.
    assign clr_step      = clr_active_q && bus_grant && (state_q == StHold);
    assign clr_last      = (clr_addr_q == ClrLast);
    assign clr_addr_cur  = clr_addr_q;
    assign clr_addr_next = clr_addr_q + 20'd1;
    assign clr_rgb_cur   = clr_rgb_q;
    assign clr_rgb_start = clear_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_active_q <= 1'b0;
            clr_addr_q   <= '0;
            clr_rgb_q    <= '0;
        end else if (clr_start) begin
            clr_active_q <= 1'b1;
            clr_addr_q   <= '0;
            clr_rgb_q    <= clear_rgb;
        end else if (clr_step) begin
            if (clr_last) clr_active_q <= 1'b0;
            else          clr_addr_q   <= clr_addr_q + 20'd1;
        end
    end
`else
    assign clr_active    = 1'b0;
    assign clr_start     = 1'b0;
    assign clr_last      = 1'b0;
    assign clr_addr_cur  = '0;
    assign clr_addr_next = '0;
    assign clr_rgb_cur   = '0;
    assign clr_rgb_start = '0;
`endif

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        pop       = 1'b0;
        oob_pop   = 1'b0;

        if (!bus_grant) begin
            // Losing the bus abandons the write; the head stays queued for a full retry.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_active) begin
                        state_d   = StSetup;
                        load_en   = 1'b1;
                        load_addr = clr_addr_cur;
                        load_data = clr_rgb_cur;
                    end else if (clr_start) begin
                        state_d   = StSetup;
                        load_en   = 1'b1;
                        load_addr = '0;
                        load_data = clr_rgb_start;
                    end else if (!fifo_empty) begin
                        if (entry_oob(head)) begin
                            pop     = 1'b1;
                            oob_pop = 1'b1;
                        end else begin
                            state_d   = StSetup;
                            load_en   = 1'b1;
                            load_addr = entry_addr(head);
                            load_data = head.rgb;
                        end
                    end
                end
                StSetup:  state_d = StStrobe;
                StStrobe: state_d = StHold;
                StHold: begin
                    if (clr_active) begin
                        if (clr_last) begin
                            state_d = StIdle;
                        end else begin
                            state_d   = StSetup;
                            load_en   = 1'b1;
                            load_addr = clr_addr_next;
                            load_data = clr_rgb_cur;
                        end
                    end else begin
                        pop = 1'b1;
                        if (peek_valid && !entry_oob(peek)) begin
                            state_d   = StSetup;
                            load_en   = 1'b1;
                            load_addr = entry_addr(peek);
                            load_data = peek.rgb;
                        end else begin
                            // Out-of-range successors are discarded from IDLE.
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            data_q    <= '0;
            err_oob_q <= 1'b0;
        end else begin
            if (load_en) begin
                addr_q <= load_addr;
                data_q <= load_data;
            end
            err_oob_q <= oob_pop;
        end
    end

    assign err_oob = err_oob_q;
    assign busy    = !fifo_empty || (state_q != StIdle) || clr_active;

    // ------------------------------------------------------------------
    // SRAM pins: released combinationally on grant loss or reset
    // ------------------------------------------------------------------
    assign drive_en  = bus_grant && !rst;
    assign dq_en     = drive_en && (state_q != StIdle);

    assign SRAM_ADDR = drive_en ? addr_q : {20{1'bz}};
    assign SRAM_DQ   = dq_en    ? data_q : {16{1'bz}};
    assign SRAM_CE_N = drive_en ? 1'b0 : 1'bz;
    assign SRAM_OE_N = drive_en ? 1'b1 : 1'bz;
    assign SRAM_WE_N = drive_en ? (state_q != StStrobe) : 1'bz;
    assign SRAM_UB_N = drive_en ? 1'b0 : 1'bz;
    assign SRAM_LB_N = drive_en ? 1'b0 : 1'bz;

endmodule
